// File: rtl/word_stream_transmitter.sv
// Word stream transmitter: queues {word, nbytes} requests and feeds the selected
// bytes of each word to a byte UART through a start/done handshake.
module word_stream_transmitter #(
    parameter int NB_DATA    = 32,
    parameter int NB_BYTE    = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int MSB_FIRST  = 1,
    localparam int NBYTES_MAX = NB_DATA / NB_BYTE,
    localparam int NB_CNT     = $clog2(NBYTES_MAX) + 1
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic [NB_DATA-1:0] i_tx_data,
    input  logic [NB_CNT-1:0]  i_tx_nbytes,
    input  logic               i_tx_push,
    input  logic               i_tx_done,
    output logic [NB_BYTE-1:0] o_tx_data,
    output logic               o_tx_start,
    output logic               o_tx_done_word,
    output logic               o_push_err,
    output logic               o_full,
    output logic               o_empty,
    output logic               o_busy
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int OCC_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, START, WAIT} state_t;
    state_t state, next_state;

    logic [NB_DATA-1:0] fifo_data   [FIFO_DEPTH];
    logic [NB_CNT-1:0]  fifo_nbytes [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [OCC_W-1:0]   count;
    logic [NB_DATA-1:0] shift_reg, head_aligned;
    logic [NB_CNT-1:0]  remaining, push_nbytes;
    logic               push_ok, push_bad, pop, byte_done, word_done;

    assign o_full      = (count == OCC_W'(FIFO_DEPTH));
    assign o_empty     = (count == '0);
    assign o_busy      = (state != IDLE);
    assign push_ok     = i_tx_push && !o_full && (i_tx_nbytes != '0);
    assign push_bad    = i_tx_push && !push_ok;
    assign pop         = (state == IDLE) && !o_empty;
    assign push_nbytes = (i_tx_nbytes > NB_CNT'(NBYTES_MAX)) ? NB_CNT'(NBYTES_MAX) : i_tx_nbytes;
    assign byte_done   = (state == WAIT) && i_tx_done;
    assign word_done   = byte_done && (remaining == NB_CNT'(1));

    // MSB-first words are pre-shifted so the first selected byte sits at the top
    always_comb begin
        head_aligned = fifo_data[rd_ptr];
        if (MSB_FIRST != 0)
            head_aligned = fifo_data[rd_ptr] << (NB_BYTE * (NBYTES_MAX - int'(fifo_nbytes[rd_ptr])));
    end

    assign o_tx_data = (MSB_FIRST != 0) ? shift_reg[NB_DATA-1 -: NB_BYTE] : shift_reg[NB_BYTE-1:0];

    always_ff @(posedge i_clock) begin
        if (!i_reset && push_ok) begin
            fifo_data[wr_ptr]   <= i_tx_data;
            fifo_nbytes[wr_ptr] <= push_nbytes;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            o_push_err <= 1'b0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            o_push_err <= push_bad;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        o_tx_start = 1'b0;
        case (state)
            IDLE: begin
                if (!o_empty)
                    next_state = START;
            end
            START: begin
                o_tx_start = 1'b1;
                next_state = WAIT;
            end
            WAIT: begin
                if (i_tx_done)
                    next_state = (remaining == NB_CNT'(1)) ? IDLE : START;
            end
            default: next_state = IDLE;
        endcase
    end

    // The last byte is never shifted out, so the final byte stays visible until IDLE
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            shift_reg      <= '0;
            remaining      <= '0;
            o_tx_done_word <= 1'b0;
        end else begin
            o_tx_done_word <= word_done;
            if (pop) begin
                shift_reg <= head_aligned;
                remaining <= fifo_nbytes[rd_ptr];
            end else if (byte_done && !word_done) begin
                shift_reg <= (MSB_FIRST != 0) ? (shift_reg << NB_BYTE) : (shift_reg >> NB_BYTE);
                remaining <= remaining - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_word_stream_transmitter.sv
// Self-checking bench for word_stream_transmitter: vector table plus scoreboard
// of expected UART bytes, with hand-written sequences for multi-cycle corners.
module tb_word_stream_transmitter;

    localparam int RESP_DELAY = 6;

    logic        clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset;
    logic [31:0] tx_data;
    logic [2:0]  tx_nbytes;
    logic        tx_push, tx_done;
    logic [7:0]  out_data;
    logic        out_start, out_done_word, out_push_err, out_full, out_empty, out_busy;

    logic [31:0] l_data;
    logic [2:0]  l_nbytes;
    logic        l_push, l_done;
    logic [7:0]  l_out_data;
    logic        l_start, l_done_word, l_push_err, l_full, l_empty, l_busy;

    word_stream_transmitter dut (
        .i_clock(clock), .i_reset(reset), .i_tx_data(tx_data), .i_tx_nbytes(tx_nbytes),
        .i_tx_push(tx_push), .i_tx_done(tx_done), .o_tx_data(out_data), .o_tx_start(out_start),
        .o_tx_done_word(out_done_word), .o_push_err(out_push_err), .o_full(out_full),
        .o_empty(out_empty), .o_busy(out_busy)
    );

    word_stream_transmitter #(.MSB_FIRST(0)) dut_lsb (
        .i_clock(clock), .i_reset(reset), .i_tx_data(l_data), .i_tx_nbytes(l_nbytes),
        .i_tx_push(l_push), .i_tx_done(l_done), .o_tx_data(l_out_data), .o_tx_start(l_start),
        .o_tx_done_word(l_done_word), .o_push_err(l_push_err), .o_full(l_full),
        .o_empty(l_empty), .o_busy(l_busy)
    );

    typedef struct {
        logic [31:0] data;
        logic [2:0]  nbytes;
        int          exp_count;
    } vec_t;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         start_cnt = 0;
    int         done_cnt = 0;
    int         start_cyc_q[$];
    int         done_cyc_q[$];
    logic [7:0] exp_bytes[$];
    logic [7:0] cur_byte;
    bit         hold_done = 1'b0;
    bit         resp_pending = 1'b0;
    int         resp_cnt = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic check_output();
        check("rst_tx_data", {24'h0, out_data}, 32'h0);
        check("rst_tx_start", {31'h0, out_start}, 32'h0);
        check("rst_done_word", {31'h0, out_done_word}, 32'h0);
        check("rst_push_err", {31'h0, out_push_err}, 32'h0);
        check("rst_full", {31'h0, out_full}, 32'h0);
        check("rst_empty", {31'h0, out_empty}, 32'h1);
        check("rst_busy", {31'h0, out_busy}, 32'h0);
    endtask

    // Expected UART order: selected bytes from the highest one down to byte 0
    task automatic push_expected(input logic [31:0] data, input int count);
        for (int i = count - 1; i >= 0; i--)
            exp_bytes.push_back(data[i*8 +: 8]);
    endtask

    task automatic apply_stimulus(input logic [31:0] data, input logic [2:0] nbytes,
                                  input int count, output int push_cyc);
        @(negedge clock);
        tx_data   = data;
        tx_nbytes = nbytes;
        tx_push   = 1'b1;
        push_cyc  = cyc;
        push_expected(data, count);
        @(negedge clock);
        tx_push = 1'b0;
    endtask

    task automatic wait_word(input int target);
        for (int i = 0; i < 1500; i++) begin
            if (done_cnt >= target) break;
            @(negedge clock);
        end
        check("word_done_count", done_cnt, target);
    endtask

    task automatic wait_lsb_start(output logic [7:0] b);
        b = 8'h00;
        for (int i = 0; i < 20; i++) begin
            if (l_start) begin
                b = l_out_data;
                return;
            end
            @(negedge clock);
        end
    endtask

    // Scoreboard monitor and UART model for the MSB-first instance
    initial begin
        tx_done = 1'b0;
        forever begin
            @(negedge clock);
            if (out_done_word) begin
                done_cnt++;
                done_cyc_q.push_back(cyc);
                check("done_word_after_last_done", {31'h0, tx_done}, 32'h1);
            end
            tx_done = 1'b0;
            if (reset) begin
                resp_pending = 1'b0;
                resp_cnt     = 0;
            end else if (out_start) begin
                start_cnt++;
                start_cyc_q.push_back(cyc);
                cur_byte = out_data;
                check("start_busy", {31'h0, out_busy}, 32'h1);
                if (exp_bytes.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_start: got byte 0x%0h, expected no start", out_data);
                end else begin
                    check("start_byte", {24'h0, out_data}, {24'h0, exp_bytes.pop_front()});
                end
                resp_pending = 1'b1;
                resp_cnt     = RESP_DELAY;
            end else if (resp_pending) begin
                if (resp_cnt > 1) begin
                    resp_cnt--;
                end else if (!hold_done) begin
                    check("data_stable", {24'h0, out_data}, {24'h0, cur_byte});
                    tx_done      = 1'b1;
                    resp_pending = 1'b0;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vec_t       vecs[5];
        int         push_cyc, lat, s0, d0;
        logic [7:0] got;

        vecs[0] = '{32'hAABBCC55, 3'd4, 4};
        vecs[1] = '{32'hAABBCC55, 3'd1, 1};
        vecs[2] = '{32'h11223344, 3'd7, 4};
        vecs[3] = '{32'hDEADBEEF, 3'd2, 2};
        vecs[4] = '{32'h01020304, 3'd3, 3};

        reset = 1'b1; tx_data = '0; tx_nbytes = '0; tx_push = 1'b0;
        l_data = '0; l_nbytes = '0; l_push = 1'b0; l_done = 1'b0;
        repeat (3) @(negedge clock);
        check_output();
        check("lsb_rst_empty", {31'h0, l_empty}, 32'h1);
        check("lsb_rst_busy", {31'h0, l_busy}, 32'h0);
        check("lsb_rst_full", {31'h0, l_full}, 32'h0);
        check("lsb_rst_push_err", {31'h0, l_push_err}, 32'h0);
        reset = 1'b0;

        for (int v = 0; v < 5; v++) begin
            s0 = start_cnt;
            d0 = done_cnt;
            apply_stimulus(vecs[v].data, vecs[v].nbytes, vecs[v].exp_count, push_cyc);
            lat = -1;
            for (int i = 0; i < 10; i++) begin
                if (out_start) begin
                    lat = cyc - push_cyc;
                    break;
                end
                @(negedge clock);
            end
            check("push_to_start_latency", lat, 2);
            wait_word(d0 + 1);
            check("bytes_per_word", start_cnt - s0, vecs[v].exp_count);
            check("idle_empty_after_word", {30'h0, out_empty, out_busy}, 32'h2);
        end

        start_cyc_q.delete();
        done_cyc_q.delete();
        d0 = done_cnt;
        apply_stimulus(32'h0000A1B2, 3'd2, 2, push_cyc);
        apply_stimulus(32'h0000C3D4, 3'd2, 2, push_cyc);
        wait_word(d0 + 2);
        check("gap_start_count", start_cyc_q.size(), 4);
        if (start_cyc_q.size() >= 3 && done_cyc_q.size() >= 1)
            check("inter_word_gap", start_cyc_q[2] - done_cyc_q[0], 1);

        hold_done = 1'b1;
        d0 = done_cnt;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            if (i == 4) check("not_full_before_5th", {31'h0, out_full}, 32'h0);
            if (i == 5) begin
                check("full_after_5th", {31'h0, out_full}, 32'h1);
                check("no_err_before_6th", {31'h0, out_push_err}, 32'h0);
            end
            tx_data   = 32'hA0B0C0D0 + 32'(i);
            tx_nbytes = 3'd4;
            tx_push   = 1'b1;
            if (i < 5) push_expected(tx_data, 4);
        end
        @(negedge clock);
        tx_push = 1'b0;
        check("push_err_when_full", {31'h0, out_push_err}, 32'h1);
        check("still_full", {31'h0, out_full}, 32'h1);
        hold_done = 1'b0;
        wait_word(d0 + 5);

        @(negedge clock);
        tx_data = 32'h55667788; tx_nbytes = 3'd0; tx_push = 1'b1;
        @(negedge clock);
        tx_push = 1'b0;
        check("push_err_nbytes0", {31'h0, out_push_err}, 32'h1);
        check("empty_after_nbytes0", {31'h0, out_empty}, 32'h1);
        @(negedge clock);
        check("push_err_one_cycle", {31'h0, out_push_err}, 32'h0);

        s0 = start_cnt;
        apply_stimulus(32'hCAFEF00D, 3'd4, 4, push_cyc);
        for (int i = 0; i < 60; i++) begin
            if (start_cnt >= s0 + 2) break;
            @(negedge clock);
        end
        check("two_bytes_before_reset", start_cnt - s0, 2);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        exp_bytes.delete();
        repeat (2) @(negedge clock);
        check_output();
        reset = 1'b0;
        s0 = start_cnt;
        d0 = done_cnt;
        repeat (30) @(negedge clock);
        check("no_start_after_reset", start_cnt - s0, 0);
        check("no_done_word_after_reset", done_cnt - d0, 0);

        @(negedge clock);
        l_data = 32'h12345678; l_nbytes = 3'd2; l_push = 1'b1;
        @(negedge clock);
        l_push = 1'b0;
        wait_lsb_start(got);
        check("lsb_byte0", {24'h0, got}, 32'h78);
        repeat (3) @(negedge clock);
        check("lsb_stable", {24'h0, l_out_data}, 32'h78);
        l_done = 1'b1;
        @(negedge clock);
        l_done = 1'b0;
        wait_lsb_start(got);
        check("lsb_byte1", {24'h0, got}, 32'h56);
        repeat (3) @(negedge clock);
        l_done = 1'b1;
        @(negedge clock);
        l_done = 1'b0;
        check("lsb_done_word", {31'h0, l_done_word}, 32'h1);

        repeat (2) @(negedge clock);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/word_stream_transmitter.md
WORD_STREAM_TRANSMITTER -- requirements
Module: word_stream_transmitter

Interface
REQ-001 The block SHALL have these parameters, one per line (name, default, meaning):
- NB_DATA, 32, word width; integer multiple of NB_BYTE, at least NB_BYTE.
- NB_BYTE, 8, UART byte width.
- FIFO_DEPTH, 4, request queue depth; power of 2, at least 2.
- MSB_FIRST, 1, byte order: 1 = most-significant selected byte first, 0 = least-significant first.
REQ-002 The block SHALL derive NB_CNT = clog2(NB_DATA/NB_BYTE)+1 and NBYTES_MAX = NB_DATA/NB_BYTE.
REQ-003 The block SHALL have these ports, one per line (name, direction, width, meaning):
- i_clock, in, 1, single clock; all logic on its rising edge.
- i_reset, in, 1, synchronous, active-high reset.
- i_tx_data, in, NB_DATA, word to enqueue.
- i_tx_nbytes, in, NB_CNT, number of low-order bytes of i_tx_data to send.
- i_tx_push, in, 1, enqueue request.
- i_tx_done, in, 1, UART byte-complete pulse.
- o_tx_data, out, NB_BYTE, byte presented to the UART.
- o_tx_start, out, 1, one-cycle UART start pulse.
- o_tx_done_word, out, 1, one-cycle pulse when a word completes.
- o_push_err, out, 1, one-cycle pulse when a push is rejected.
- o_full, out, 1, FIFO full.
- o_empty, out, 1, FIFO empty.
- o_busy, out, 1, FSM not IDLE.

Function
REQ-004 The FIFO SHALL store {data, nbytes} entries, up to FIFO_DEPTH of them.
REQ-005 A push is accepted at a clock edge when i_tx_push=1, o_full=0 and i_tx_nbytes!=0 (o_full is the value before that edge).
REQ-006 A push SHALL be rejected when o_full=1, even if a pop occurs on the same edge; o_push_err pulses for 1 cycle after the edge; FIFO contents unchanged.
REQ-007 A push with i_tx_nbytes=0 SHALL be rejected with an o_push_err pulse.
REQ-008 Values of i_tx_nbytes greater than NBYTES_MAX SHALL be clamped to NBYTES_MAX at enqueue.
REQ-009 A simultaneous accepted push and pop SHALL leave the occupancy count unchanged; read and write pointers wrap modulo FIFO_DEPTH.
REQ-010 The FSM SHALL have states IDLE, START, WAIT.
REQ-011 IDLE: when the FIFO is non-empty, the block SHALL pop the head, latch data into a shift register and nbytes into a remaining counter, and go to START.
REQ-012 START: o_tx_start=1 for exactly one cycle with o_tx_data = current byte; the FSM then goes to WAIT unconditionally.
REQ-013 WAIT: i_tx_done=1 with remaining>1 SHALL advance to the next byte, decrement remaining, and go to START.
REQ-014 WAIT: i_tx_done=1 with remaining=1 SHALL pulse o_tx_done_word for 1 cycle after the edge and go to IDLE.
REQ-015 i_tx_done SHALL be ignored in IDLE and START.
REQ-016 Byte order: for nbytes=k with MSB_FIRST=1, the block SHALL send bytes k-1 down to 0 of the word.
REQ-017 Byte order: for nbytes=k with MSB_FIRST=0, the block SHALL send bytes 0 up to k-1.
REQ-018 Bytes at index k and above SHALL never be sent.
REQ-019 o_tx_data SHALL stay stable from START until i_tx_done is sampled in WAIT.
REQ-020 Latency: a push accepted at edge E0 into an empty FIFO while IDLE SHALL produce o_tx_start in the cycle after E1.
REQ-021 i_tx_done at edge En SHALL produce the next o_tx_start in the cycle after En.
REQ-022 Inter-word gap SHALL be exactly one IDLE cycle.
REQ-023 o_busy SHALL equal (state != IDLE); o_full and o_empty SHALL reflect the registered occupancy count.

Reset
REQ-024 When i_reset=1 at an edge, the block SHALL go to IDLE, flush the FIFO (pointers and count = 0) and clear the shift register and counter.
REQ-025 Reset values SHALL be: o_tx_data=0, o_tx_start=0, o_tx_done_word=0, o_push_err=0, o_full=0, o_empty=1, o_busy=0.
REQ-026 i_reset SHALL take priority over every other input.
REQ-027 On reset mid-word, the remaining bytes SHALL be discarded, with no o_tx_done_word.

Verification
REQ-028 Default parameters; push 0xAABBCC55, nbytes=4; send i_tx_done 6 cycles after each start -> starts with 0xAA, 0xBB, 0xCC, 0x55; o_tx_done_word one cycle after the 4th done.
REQ-029 Push 0xAABBCC55, nbytes=1 -> a single start with 0x55, then o_tx_done_word.
REQ-030 MSB_FIRST=0; push 0x12345678, nbytes=2 -> 0x78, then 0x56.
REQ-031 Six pushes at consecutive edges with i_tx_done held low -> first popped; o_full=1 after 5th; 6th rejected with o_push_err.
REQ-032 nbytes=0 -> o_push_err, o_empty stays 1; nbytes=7 with 32-bit word 0x11223344 -> four bytes 0x11, 0x22, 0x33, 0x44.
REQ-033 Reset asserted after the 2nd byte of a queued 4-byte word -> all outputs at reset values; no o_tx_start until a new push.
